// File: rtl/uart_rx_word_if.sv
// Serial-in / word-out bundle between the UART receive front end and the hub.
// The receiver (master) samples rx and drives the word and strobes.
interface uart_rx_word_if;
   logic        rx;
   logic [31:0] dout;
   logic        data_ready;
   logic        frame_err;
   logic        timeout_err;
   logic        busy;

   modport master (input rx, output dout, data_ready, frame_err, timeout_err, busy);
   modport slave  (output rx, input dout, data_ready, frame_err, timeout_err, busy);
endinterface

// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that packs four consecutive bytes into a 32-bit word,
// with framing-error and inter-byte gap timeout strobes.
module uart_rx_word #(
   parameter int CLKS_PER_BIT = 434,
   parameter int TIMEOUT_BITS = 20
) (
   input logic           clk,
   input logic           rst,
   uart_rx_word_if.master bus
);
   localparam int BW      = $clog2(CLKS_PER_BIT) + 1;
   localparam int GAP_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int GW      = $clog2(GAP_MAX + 1);
   localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);
   localparam logic [GW-1:0] GAP_M1  = GW'(GAP_MAX - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state;
   logic            rx_m, rx_s, rx_q;
   logic [BW-1:0]   baud;
   logic [GW-1:0]   gap;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic [1:0]      byte_cnt;
   logic [2:0][7:0] word;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         rx_m            <= 1'b1;
         rx_s            <= 1'b1;
         rx_q            <= 1'b1;
         baud            <= '0;
         gap             <= '0;
         bit_idx         <= '0;
         shreg           <= '0;
         byte_cnt        <= '0;
         word            <= '0;
         bus.dout        <= '0;
         bus.data_ready  <= 1'b0;
         bus.frame_err   <= 1'b0;
         bus.timeout_err <= 1'b0;
         bus.busy        <= 1'b0;
      end else begin
         rx_m            <= bus.rx;
         rx_s            <= rx_m;
         rx_q            <= rx_s;
         bus.data_ready  <= 1'b0;
         bus.frame_err   <= 1'b0;
         bus.timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               // A start edge wins over a timeout landing in the same cycle.
               if (rx_q && !rx_s) begin
                  state    <= START;
                  baud     <= '0;
                  gap      <= '0;
                  bus.busy <= 1'b1;
               end else if (byte_cnt == 2'd0) begin
                  gap <= '0;
               end else if (gap == GAP_M1) begin
                  gap             <= '0;
                  byte_cnt        <= '0;
                  bus.timeout_err <= 1'b1;
               end else begin
                  gap <= gap + GW'(1);
               end
            end
            START: begin
               if (baud == HALF_M1) begin
                  baud <= '0;
                  if (rx_s) begin
                     state    <= IDLE;
                     bus.busy <= 1'b0;
                  end else begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            DATA: begin
               if (baud == FULL_M1) begin
                  baud    <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            STOP: begin
               // Leave mid stop bit so a back-to-back start edge is not missed.
               if (baud == FULL_M1) begin
                  baud     <= '0;
                  state    <= IDLE;
                  bus.busy <= 1'b0;
                  if (rx_s) begin
                     byte_cnt <= byte_cnt + 2'd1;
                     case (byte_cnt)
                        2'd0:    word[0] <= shreg;
                        2'd1:    word[1] <= shreg;
                        2'd2:    word[2] <= shreg;
                        default: begin
                           bus.dout       <= {shreg, word[2], word[1], word[0]};
                           bus.data_ready <= 1'b1;
                        end
                     endcase
                  end else begin
                     byte_cnt      <= '0;
                     bus.frame_err <= 1'b1;
                  end
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word: serial frames driven on rx, strobes and
// captured words checked against hand-computed values.
module tb_uart_rx_word;
   localparam int CPB = 16;
   localparam int TOB = 20;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   uart_rx_word_if bus ();

   uart_rx_word #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // Strobe monitor: counts pulses, records delivered words, tracks busy-low runs.
   int          n_rdy = 0, n_ferr = 0, n_tout = 0, n_multi = 0;
   logic [31:0] words[$];
   bit          track_busy = 1'b0;
   int          low_run = 0, max_low = 0;

   always @(negedge clk) begin
      if (bus.data_ready === 1'b1) begin
         n_rdy = n_rdy + 1;
         words.push_back(bus.dout);
      end
      if (bus.frame_err === 1'b1)   n_ferr = n_ferr + 1;
      if (bus.timeout_err === 1'b1) n_tout = n_tout + 1;
      if ((int'(bus.data_ready === 1'b1) + int'(bus.frame_err === 1'b1) +
           int'(bus.timeout_err === 1'b1)) > 1) n_multi = n_multi + 1;
      if (track_busy) begin
         if (bus.busy === 1'b0) low_run = low_run + 1;
         else begin
            if (low_run > max_low) max_low = low_run;
            low_run = 0;
         end
      end else low_run = 0;
   end

   task automatic drive_bit(input logic v);
      bus.rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop);
      bus.rx = 1'b1;
   endtask

   task automatic idle_bits(input int n);
      bus.rx = 1'b1;
      repeat (n * CPB) @(negedge clk);
   endtask

   task automatic test_reset();
      bus.rx = 1'b1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.dout !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", bus.dout); end
      checks++; if (bus.data_ready !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", bus.data_ready); end
      checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", bus.frame_err); end
      checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_tout got=%b exp=0", bus.timeout_err); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      rst = 1'b1;
      idle_bits(2);
   endtask

   task automatic test_single_word();
      int r0, f0, t0;
      r0 = n_rdy; f0 = n_ferr; t0 = n_tout;
      send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
      send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
      idle_bits(2);
      checks++; if (n_rdy - r0 !== 1) begin failures++; $display("FAIL word1_rdy_count got=%0d exp=1", n_rdy - r0); end
      checks++; if (words[words.size()-1] !== 32'h12345678) begin failures++; $display("FAIL word1_dout got=%h exp=12345678", words[words.size()-1]); end
      checks++; if ((n_ferr - f0) + (n_tout - t0) !== 0) begin failures++; $display("FAIL word1_err_strobes got=%0d exp=0", (n_ferr - f0) + (n_tout - t0)); end
      checks++; if (bus.dout !== 32'h12345678) begin failures++; $display("FAIL word1_dout_hold got=%h exp=12345678", bus.dout); end
   endtask

   task automatic test_back_to_back();
      int r0, f0, t0;
      logic [31:0] w [2];
      r0 = n_rdy; f0 = n_ferr; t0 = n_tout;
      w[0] = 32'hDEADBEEF; w[1] = 32'h00000001;
      track_busy = 1'b1;
      for (int k = 0; k < 2; k++)
         for (int b = 0; b < 4; b++) send_byte(w[k][8*b +: 8], 1'b1);
      track_busy = 1'b0;
      idle_bits(2);
      checks++; if (n_rdy - r0 !== 2) begin failures++; $display("FAIL b2b_rdy_count got=%0d exp=2", n_rdy - r0); end
      checks++; if (words[r0] !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_word0 got=%h exp=deadbeef", words[r0]); end
      checks++; if (words[r0+1] !== 32'h00000001) begin failures++; $display("FAIL b2b_word1 got=%h exp=00000001", words[r0+1]); end
      checks++; if ((n_ferr - f0) + (n_tout - t0) !== 0) begin failures++; $display("FAIL b2b_err_strobes got=%0d exp=0", (n_ferr - f0) + (n_tout - t0)); end
      // Idle between frames is the second half of the stop bit.
      checks++; if (max_low < 1 || max_low > CPB/2 + 2) begin failures++; $display("FAIL b2b_busy_low got=%0d exp=1..%0d", max_low, CPB/2 + 2); end
   endtask

   task automatic test_frame_err();
      int r0, f0, t0;
      r0 = n_rdy; f0 = n_ferr; t0 = n_tout;
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b0);
      idle_bits(1);
      checks++; if (n_ferr - f0 !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", n_ferr - f0); end
      send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
      idle_bits(2);
      checks++; if (n_rdy - r0 !== 1) begin failures++; $display("FAIL ferr_rdy_count got=%0d exp=1", n_rdy - r0); end
      checks++; if (words[words.size()-1] !== 32'h44332211) begin failures++; $display("FAIL ferr_next_word got=%h exp=44332211", words[words.size()-1]); end
      checks++; if (n_tout - t0 !== 0) begin failures++; $display("FAIL ferr_tout got=%0d exp=0", n_tout - t0); end
   endtask

   task automatic test_timeout();
      int r0, f0, t0;
      r0 = n_rdy; f0 = n_ferr; t0 = n_tout;
      send_byte(8'hC1, 1'b1); send_byte(8'hC2, 1'b1);
      idle_bits(TOB + 1);
      checks++; if (n_tout - t0 !== 1) begin failures++; $display("FAIL tout_count got=%0d exp=1", n_tout - t0); end
      checks++; if (n_rdy - r0 !== 0) begin failures++; $display("FAIL tout_no_rdy got=%0d exp=0", n_rdy - r0); end
      send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
      idle_bits(2);
      checks++; if (words[words.size()-1] !== 32'h04030201 || n_rdy - r0 !== 1) begin failures++; $display("FAIL tout_fresh_word got=%h exp=04030201", words[words.size()-1]); end
      idle_bits(TOB + 5);
      checks++; if (n_tout - t0 !== 1) begin failures++; $display("FAIL tout_idle_empty got=%0d exp=1", n_tout - t0); end
      checks++; if (n_ferr - f0 !== 0) begin failures++; $display("FAIL tout_ferr got=%0d exp=0", n_ferr - f0); end
   endtask

   task automatic test_glitch();
      int r0, f0, t0;
      r0 = n_rdy; f0 = n_ferr; t0 = n_tout;
      send_byte(8'hA1, 1'b1); send_byte(8'hB2, 1'b1);
      idle_bits(1);
      bus.rx = 1'b0;
      repeat (4) @(negedge clk);
      idle_bits(2);
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%b exp=0", bus.busy); end
      checks++; if ((n_rdy - r0) + (n_ferr - f0) + (n_tout - t0) !== 0) begin failures++; $display("FAIL glitch_strobes got=%0d exp=0", (n_rdy - r0) + (n_ferr - f0) + (n_tout - t0)); end
      send_byte(8'hC3, 1'b1); send_byte(8'hD4, 1'b1);
      idle_bits(2);
      checks++; if (n_rdy - r0 !== 1) begin failures++; $display("FAIL glitch_rdy_count got=%0d exp=1", n_rdy - r0); end
      checks++; if (words[words.size()-1] !== 32'hD4C3B2A1) begin failures++; $display("FAIL glitch_word got=%h exp=d4c3b2a1", words[words.size()-1]); end
   endtask

   task automatic test_reset_mid_frame();
      int r0, f0, t0;
      r0 = n_rdy; f0 = n_ferr; t0 = n_tout;
      send_byte(8'h5A, 1'b1); send_byte(8'h6B, 1'b1);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      bus.rx = 1'b0;
      repeat (CPB/2) @(negedge clk);
      rst = 1'b0;
      bus.rx = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.dout !== 32'h0) begin failures++; $display("FAIL rstmid_dout got=%h exp=0", bus.dout); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.data_ready !== 1'b0) begin failures++; $display("FAIL rstmid_rdy got=%b exp=0", bus.data_ready); end
      rst = 1'b1;
      idle_bits(2);
      checks++; if ((n_rdy - r0) + (n_ferr - f0) + (n_tout - t0) !== 0) begin failures++; $display("FAIL rstmid_strobes got=%0d exp=0", (n_rdy - r0) + (n_ferr - f0) + (n_tout - t0)); end
      send_byte(8'h9A, 1'b1); send_byte(8'hBC, 1'b1);
      send_byte(8'hDE, 1'b1); send_byte(8'hF0, 1'b1);
      idle_bits(2);
      checks++; if (n_rdy - r0 !== 1) begin failures++; $display("FAIL rstmid_rdy_count got=%0d exp=1", n_rdy - r0); end
      checks++; if (words[words.size()-1] !== 32'hF0DEBC9A) begin failures++; $display("FAIL rstmid_word got=%h exp=f0debc9a", words[words.size()-1]); end
      checks++; if ((n_ferr - f0) + (n_tout - t0) !== 0) begin failures++; $display("FAIL rstmid_err got=%0d exp=0", (n_ferr - f0) + (n_tout - t0)); end
   endtask

   task automatic test_exclusive();
      checks++; if (n_multi !== 0) begin failures++; $display("FAIL strobe_exclusive got=%0d exp=0", n_multi); end
   endtask

   initial begin
      bus.rx = 1'b1;
      @(negedge clk);
      test_reset();
      test_single_word();
      test_back_to_back();
      test_frame_err();
      test_timeout();
      test_glitch();
      test_reset_mid_frame();
      test_exclusive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
